// File: rtl/probe_cmd_st_if.sv
// rtl/probe_cmd_st_if.sv - key-strobe inputs and probe-state outputs of probe_cmd_st
interface probe_cmd_st_if #(
   parameter int ST_W = 4
);
   logic [7:0]      ASCII;
   logic            ASCII_EN;
   logic            K_ENTER;
   logic            K_ESC;
   logic [ST_W-1:0] PRB_ST;
   logic            CLR_XPOS;
   logic            SEL_STB;
   logic [ST_W-1:0] SEL_IDX;
   logic            TIMEOUT;

   // keyboard-decoder side: drives key strobes, observes probe state
   modport master (
      output ASCII, ASCII_EN, K_ENTER, K_ESC,
      input  PRB_ST, CLR_XPOS, SEL_STB, SEL_IDX, TIMEOUT
   );

   // state-machine side
   modport slave (
      input  ASCII, ASCII_EN, K_ENTER, K_ESC,
      output PRB_ST, CLR_XPOS, SEL_STB, SEL_IDX, TIMEOUT
   );
endinterface

// File: rtl/probe_cmd_st.sv
// rtl/probe_cmd_st.sv - keyboard probe command FSM; PROBE_CASE_FOLD_EN folds lowercase keys
module probe_cmd_st #(
   parameter int         NUM_MODES     = 3,
   parameter int         ST_W          = 4,
   parameter logic [7:0] BASE_CHAR     = 8'h41,
   parameter int         ONESHOT_MODES = 1,
   parameter int         TO_W          = 24,
   parameter int         TIMEOUT_CYC   = 0
) (
   input  logic          CLK,
   input  logic          RST,
   probe_cmd_st_if.slave bus
);

   typedef enum logic [ST_W-1:0] {
      ST_IDLE  = ST_W'(0),
      ST_ARMED = ST_W'(1)
   } st_e;

   localparam logic [ST_W-1:0] ST_LAST  = ST_W'(NUM_MODES + 1);
   localparam logic [ST_W-1:0] ST_CLR   = ST_W'(2);
   localparam logic [ST_W-1:0] N_ONESHOT = ST_W'(ONESHOT_MODES);
   localparam logic [TO_W-1:0] TO_LAST  = TO_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
   localparam logic [8:0]      HIT_END  = 9'(BASE_CHAR) + 9'(NUM_MODES);

   logic [ST_W-1:0] st;
   logic [ST_W-1:0] sel_idx;
   logic            clr_xpos;
   logic            sel_stb;
   logic            timeout;
   logic            mode_new;
   logic [TO_W-1:0] cnt;

   logic [7:0]      ascii_f;
   logic [7:0]      diff;
   logic            hit;
   logic [ST_W-1:0] idx;
   logic [ST_W-1:0] mode;

   // key decode: optional case fold, then range match against the mode keys
   always_comb begin
      ascii_f = bus.ASCII;
`ifdef PROBE_CASE_FOLD_EN
      if (bus.ASCII >= 8'h61 && bus.ASCII <= 8'h7A)
         ascii_f = bus.ASCII & 8'hDF;
`endif
      diff = ascii_f - BASE_CHAR;
      idx  = ST_W'(diff);
      hit  = bus.ASCII_EN && (ascii_f >= BASE_CHAR) && ({1'b0, ascii_f} < HIT_END);
      mode = st - ST_W'(2);
   end

   // state transitions, arm timeout counter and all registered outputs
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         st       <= ST_IDLE;
         sel_idx  <= '0;
         clr_xpos <= 1'b0;
         sel_stb  <= 1'b0;
         timeout  <= 1'b0;
         mode_new <= 1'b0;
         cnt      <= '0;
      end else begin
         clr_xpos <= (st == ST_CLR);
         sel_stb  <= mode_new;
         mode_new <= 1'b0;
         timeout  <= 1'b0;
         if (st == ST_IDLE) begin
            if (bus.K_ENTER) begin
               st  <= ST_ARMED;
               cnt <= '0;
            end
         end else if (st == ST_ARMED) begin
            if (bus.K_ESC) begin
               st <= ST_IDLE;
            end else if (hit) begin
               st       <= idx + ST_W'(2);
               sel_idx  <= idx;
               mode_new <= 1'b1;
            end else if (TIMEOUT_CYC != 0 && cnt == TO_LAST) begin
               st      <= ST_IDLE;
               timeout <= 1'b1;
            end else if (cnt != '1) begin
               cnt <= cnt + TO_W'(1);
            end
         end else if (st <= ST_LAST) begin
            // one-shot modes last a single cycle; persistent ones wait for Esc or a new key
            if (mode < N_ONESHOT) begin
               st <= ST_IDLE;
            end else if (bus.K_ESC) begin
               st <= ST_IDLE;
            end else if (hit) begin
               st       <= idx + ST_W'(2);
               sel_idx  <= idx;
               mode_new <= 1'b1;
            end
         end else begin
            st <= ST_IDLE;
         end
      end
   end

   assign bus.PRB_ST   = st;
   assign bus.SEL_IDX  = sel_idx;
   assign bus.CLR_XPOS = clr_xpos;
   assign bus.SEL_STB  = sel_stb;
   assign bus.TIMEOUT  = timeout;

endmodule

// File: tb/tb_probe_cmd_st.sv
// tb/tb_probe_cmd_st.sv - directed bench for probe_cmd_st (default and TIMEOUT_CYC=5 instances)
module tb_probe_cmd_st;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] ascii = 8'h00;
   logic       ascii_en = 1'b0;
   logic       k_enter = 1'b0;
   logic       k_esc = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   probe_cmd_st_if #(.ST_W(4)) if0 ();
   probe_cmd_st_if #(.ST_W(4)) if5 ();

   assign if0.ASCII    = ascii;
   assign if0.ASCII_EN = ascii_en;
   assign if0.K_ENTER  = k_enter;
   assign if0.K_ESC    = k_esc;
   assign if5.ASCII    = ascii;
   assign if5.ASCII_EN = ascii_en;
   assign if5.K_ENTER  = k_enter;
   assign if5.K_ESC    = k_esc;

   probe_cmd_st d0 (.CLK(clk), .RST(rst), .bus(if0.slave));
   probe_cmd_st #(.TIMEOUT_CYC(5)) d5 (.CLK(clk), .RST(rst), .bus(if5.slave));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // present one cycle of inputs, return 1 time unit after the capturing edge
   task automatic key(input logic [7:0] a, input logic en, input logic ent, input logic esc);
      ascii    = a;
      ascii_en = en;
      k_enter  = ent;
      k_esc    = esc;
      @(posedge clk);
      #1;
      ascii    = 8'h00;
      ascii_en = 1'b0;
      k_enter  = 1'b0;
      k_esc    = 1'b0;
   endtask

   task automatic idle();
      key(8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      do_reset();
      check("rst_st", 32'(if0.PRB_ST), 0);
      check("rst_clr", 32'(if0.CLR_XPOS), 0);
      check("rst_stb", 32'(if0.SEL_STB), 0);
      check("rst_idx", 32'(if0.SEL_IDX), 0);
      check("rst_to", 32'(if5.TIMEOUT), 0);

      // one-shot mode 0
      key(8'h00, 1'b0, 1'b1, 1'b0);
      check("t1_armed", 32'(if0.PRB_ST), 1);
      key(8'h41, 1'b1, 1'b0, 1'b0);
      check("t1_mode0", 32'(if0.PRB_ST), 2);
      check("t1_stb_early", 32'(if0.SEL_STB), 0);
      check("t1_clr_early", 32'(if0.CLR_XPOS), 0);
      idle();
      check("t1_back", 32'(if0.PRB_ST), 0);
      check("t1_clr", 32'(if0.CLR_XPOS), 1);
      check("t1_stb", 32'(if0.SEL_STB), 1);
      check("t1_idx", 32'(if0.SEL_IDX), 0);
      idle();
      check("t1_clr_off", 32'(if0.CLR_XPOS), 0);
      check("t1_stb_off", 32'(if0.SEL_STB), 0);

      // persistent modes, reselection, Esc
      key(8'h00, 1'b0, 1'b1, 1'b0);
      key(8'h43, 1'b1, 1'b0, 1'b0);
      check("t2_mode2", 32'(if0.PRB_ST), 4);
      check("t2_idx2", 32'(if0.SEL_IDX), 2);
      idle();
      check("t2_hold", 32'(if0.PRB_ST), 4);
      check("t2_stb1", 32'(if0.SEL_STB), 1);
      key(8'h00, 1'b0, 1'b1, 1'b0);
      check("t2_enter_ign", 32'(if0.PRB_ST), 4);
      check("t2_stb1_off", 32'(if0.SEL_STB), 0);
      key(8'h42, 1'b1, 1'b0, 1'b0);
      check("t2_mode1", 32'(if0.PRB_ST), 3);
      check("t2_idx1", 32'(if0.SEL_IDX), 1);
      idle();
      check("t2_stb2", 32'(if0.SEL_STB), 1);
      key(8'h00, 1'b0, 1'b0, 1'b1);
      check("t2_esc", 32'(if0.PRB_ST), 0);

      // out-of-range keys ignored; Esc beats a hit
      key(8'h00, 1'b0, 1'b1, 1'b0);
      key(8'h44, 1'b1, 1'b0, 1'b0);
      check("t3_D", 32'(if0.PRB_ST), 1);
      key(8'h20, 1'b1, 1'b0, 1'b0);
      check("t3_space", 32'(if0.PRB_ST), 1);
      key(8'h41, 1'b1, 1'b0, 1'b1);
      check("t3_esc_hit", 32'(if0.PRB_ST), 0);
      idle();
      check("t3_no_stb", 32'(if0.SEL_STB), 0);
      check("t3_idx_kept", 32'(if0.SEL_IDX), 1);

      // arm timeout of 5 cycles
      do_reset();
      key(8'h00, 1'b0, 1'b1, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         idle();
         check($sformatf("t4_armed_%0d", i), 32'(if5.PRB_ST), 1);
         check($sformatf("t4_no_to_%0d", i), 32'(if5.TIMEOUT), 0);
      end
      idle();
      check("t4_expire", 32'(if5.PRB_ST), 0);
      check("t4_to", 32'(if5.TIMEOUT), 1);
      check("t4_no_to_dflt", 32'(if0.PRB_ST), 1);
      key(8'h00, 1'b0, 1'b0, 1'b1);
      check("t4_to_off", 32'(if5.TIMEOUT), 0);
      check("t4_dflt_esc", 32'(if0.PRB_ST), 0);

      // key on the last armed cycle wins over the timeout
      key(8'h00, 1'b0, 1'b1, 1'b0);
      for (int i = 1; i <= 4; i++) idle();
      check("t4b_armed", 32'(if5.PRB_ST), 1);
      key(8'h43, 1'b1, 1'b0, 1'b0);
      check("t4b_mode", 32'(if5.PRB_ST), 4);
      check("t4b_no_to", 32'(if5.TIMEOUT), 0);
      idle();
      check("t4b_no_to2", 32'(if5.TIMEOUT), 0);
      check("t4b_stb", 32'(if5.SEL_STB), 1);
      check("t4b_persist", 32'(if5.PRB_ST), 4);
      key(8'h00, 1'b0, 1'b0, 1'b1);

      // Enter with a key in IDLE only arms
      key(8'h42, 1'b1, 1'b1, 1'b0);
      check("t5_arm_only", 32'(if0.PRB_ST), 1);
      idle();
      check("t5_arm_hold", 32'(if0.PRB_ST), 1);
      check("t5_no_stb", 32'(if0.SEL_STB), 0);
      key(8'h42, 1'b1, 1'b0, 1'b0);
      check("t5_mode1", 32'(if0.PRB_ST), 3);
      // asynchronous reset between edges
      #2;
      rst = 1'b1;
      #1;
      check("t5_arst_st", 32'(if0.PRB_ST), 0);
      check("t5_arst_idx", 32'(if0.SEL_IDX), 0);
      check("t5_arst_stb", 32'(if0.SEL_STB), 0);
      check("t5_arst_clr", 32'(if0.CLR_XPOS), 0);
      check("t5_arst_to", 32'(if0.TIMEOUT), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // lowercase key
      key(8'h00, 1'b0, 1'b1, 1'b0);
      key(8'h62, 1'b1, 1'b0, 1'b0);
`ifdef PROBE_CASE_FOLD_EN
      check("t6_lower", 32'(if0.PRB_ST), 3);
`else
      check("t6_lower", 32'(if0.PRB_ST), 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
